pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and stalls the front end for one cycle. It flushes the three younger stages when a branch or JALR redirect resolves in MEM. It drives the operand-forwarding selects for the EX-stage ALU inputs. It also keeps saturating stall and flush event counters for bring-up and performance checks.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- IF_ID_rs1_i  in  5  IF/ID instruction bits [19:15]
- IF_ID_rs2_i  in  5  IF/ID instruction bits [24:20]
- ID_EX_rs1_i  in  5  rs1 carried into ID/EX; the ID/EX register gains this field
- ID_EX_rs2_i  in  5  rs2 carried into ID/EX; the ID/EX register gains this field
- ID_EX_rd_i  in  5  ID/EX write register
- ID_EX_mem_read_i  in  1  ID/EX holds a load
- EX_MEM_rd_i  in  5  EX/MEM write register
- EX_MEM_reg_write_i  in  1  EX/MEM register-write control
- EX_MEM_branch_i  in  1  EX/MEM branch control
- EX_MEM_zero_i  in  1  EX/MEM ALU zero flag (bit 0)
- EX_MEM_jalr_i  in  1  EX/MEM JALR control
- MEM_WB_rd_i  in  5  MEM/WB write register
- MEM_WB_reg_write_i  in  1  MEM/WB register-write control
- pc_write_o  out  1  PC register load enable
- if_id_write_o  out  1  IF/ID load enable
- id_ex_bubble_o  out  1  zero all ID/EX control fields on the next edge
- if_id_flush_o  out  1  IF/ID loads a NOP (0x00000013) on the next edge
- id_ex_flush_o  out  1  zero all ID/EX control fields on the next edge
- ex_mem_flush_o  out  1  zero all EX/MEM control fields on the next edge
- forward_a_o  out  2  ALU A select: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data
- forward_b_o  out  2  same encoding, applied before the ALU-src immediate mux
- state_o  out  2  FSM state: 00 RUN, 01 STALL, 10 REDIRECT
- stall_count_o  out  CNT_W  number of load-use stall cycles
- flush_count_o  out  CNT_W  number of redirects

## Operation
- redirect = EX_MEM_jalr_i | (EX_MEM_branch_i & EX_MEM_zero_i).
- load_use = ID_EX_mem_read_i & (ID_EX_rd_i != 0) & (ID_EX_rd_i == IF_ID_rs1_i | ID_EX_rd_i == IF_ID_rs2_i).
- Priority: redirect over load_use. When both are true, no stall is asserted and stall_count_o does not increment.
- Default outputs: pc_write_o = 1, if_id_write_o = 1, all bubble and flush outputs 0.
- On redirect: if_id_flush_o, id_ex_flush_o and ex_mem_flush_o = 1; pc_write_o = 1 so the PC takes the target.
- On load_use without redirect: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1.
- FSM transitions:
  - RUN goes to REDIRECT on redirect, to STALL on load_use, and stays in RUN otherwise.
  - STALL returns to RUN unconditionally. The load has moved to EX/MEM and ID/EX now holds a bubble, so no back-to-back stall is possible. If a redirect is detected while in STALL, it is still honoured (flushes asserted) and the FSM goes to REDIRECT.
  - REDIRECT returns to RUN. EX/MEM holds a bubble, so redirect cannot be true. If load_use is detected, it is still honoured.
- The flush and stall outputs are decoded from the current pipeline fields in every state. The state only labels the cycle that follows an event.
- Forwarding for A; B is identical using the rs2 fields:
  - 10 if EX_MEM_reg_write_i & EX_MEM_rd_i != 0 & EX_MEM_rd_i == ID_EX_rs1_i;
  - else 01 if MEM_WB_reg_write_i & MEM_WB_rd_i != 0 & MEM_WB_rd_i == ID_EX_rs1_i;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- Counters:
  - stall_count_o increments on every cycle in which id_ex_bubble_o = 1.
  - flush_count_o increments on every cycle in which redirect = 1.
  - Both saturate at 2^CNT_W − 1 and do not wrap.

## Timing
- Control outputs (pc_write, if_id_write, bubble, flushes, forward selects) are combinational from the inputs. They are valid in the same cycle and take effect on the next rising edge.
- state_o and the counters are registered and update one edge after the triggering cycle.
- While reset = 1: state = RUN, counters = 0, and outputs are forced to their defaults with forward selects 00, independent of the inputs. Reset asserted mid-stall or mid-redirect returns state_o to 00 on the next edge.
- Load-use costs exactly 1 bubble cycle. A redirect costs 3 flushed instructions.

## Test plan
- ID_EX load with rd = 5, IF_ID rs1 = 5 -> that cycle pc_write = 0, if_id_write = 0, id_ex_bubble = 1; next cycle state_o = 01 and stall_count = 1; following cycle state_o = 00 with no further stall.
- Same load but rd = 0 (x0) -> no stall; stall_count stays 0.
- EX_MEM branch = 1, zero = 1 while a load-use hazard is present -> all three flushes = 1, bubble = 0, pc_write = 1; next cycle state_o = 10 and flush_count = 1, stall_count = 0.
- EX_MEM rd = 3 (reg_write = 1), MEM_WB rd = 3 (reg_write = 1), ID_EX rs1 = 3, rs2 = 3 -> forward_a = forward_b = 10. With EX_MEM reg_write = 0 -> both 01.
- CNT_W = 2 with 5 consecutive redirect cycles -> flush_count reads 1, 2, 3, 3, 3.
- Reset asserted in the cycle after a stall (state_o = 01) -> next edge state_o = 00 and both counters = 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall, MEM-stage redirect flush and EX operand forwarding control
// for the 5-stage pipeline, with saturating stall/flush event counters.
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1_i,
  input  logic [4:0]       IF_ID_rs2_i,
  input  logic [4:0]       ID_EX_rs1_i,
  input  logic [4:0]       ID_EX_rs2_i,
  input  logic [4:0]       ID_EX_rd_i,
  input  logic             ID_EX_mem_read_i,
  input  logic [4:0]       EX_MEM_rd_i,
  input  logic             EX_MEM_reg_write_i,
  input  logic             EX_MEM_branch_i,
  input  logic             EX_MEM_zero_i,
  input  logic             EX_MEM_jalr_i,
  input  logic [4:0]       MEM_WB_rd_i,
  input  logic             MEM_WB_reg_write_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_bubble_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    REDIR = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic redirect;
  logic load_use;
  logic ex_a, ex_b, wb_a, wb_b;

  always_comb begin
    redirect = EX_MEM_jalr_i
             | (EX_MEM_branch_i & EX_MEM_zero_i);
    load_use = ID_EX_mem_read_i
             & (ID_EX_rd_i != 5'd0)
             & ((ID_EX_rd_i == IF_ID_rs1_i)
             |  (ID_EX_rd_i == IF_ID_rs2_i));
    ex_a = EX_MEM_reg_write_i
         & (EX_MEM_rd_i != 5'd0)
         & (EX_MEM_rd_i == ID_EX_rs1_i);
    ex_b = EX_MEM_reg_write_i
         & (EX_MEM_rd_i != 5'd0)
         & (EX_MEM_rd_i == ID_EX_rs2_i);
    wb_a = MEM_WB_reg_write_i
         & (MEM_WB_rd_i != 5'd0)
         & (MEM_WB_rd_i == ID_EX_rs1_i);
    wb_b = MEM_WB_reg_write_i
         & (MEM_WB_rd_i != 5'd0)
         & (MEM_WB_rd_i == ID_EX_rs2_i);
  end

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    forward_a_o    = 2'b00;
    forward_b_o    = 2'b00;
    if (!reset) begin
      if (redirect) begin
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end else if (load_use) begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
      end
      if (ex_a)      forward_a_o = 2'b10;
      else if (wb_a) forward_a_o = 2'b01;
      if (ex_b)      forward_b_o = 2'b10;
      else if (wb_b) forward_b_o = 2'b01;
    end
  end

  // Hazards are decoded in every state; the state only tags the follow-on cycle.
  always_comb begin
    state_d = RUN;
    if (!reset) begin
      unique case (state_q)
        RUN, STALL, REDIR: begin
          priority case (1'b1)
            redirect: state_d = REDIR;
            load_use: state_d = STALL;
            default:  state_d = RUN;
          endcase
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (id_ex_bubble_o && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign state_o       = state_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed + random checks of pipeline_hazard_controller against a
// rule-level model; a second instance with CNT_W = 2 exercises saturation.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_rs1, if_rs2, ex_rs1, ex_rs2, ex_rd;
  logic       ex_mr;
  logic [4:0] mem_rd;
  logic       mem_rw, mem_br, mem_z, mem_jalr;
  logic [4:0] wb_rd;
  logic       wb_rw;

  logic        pcw, ifw, bub, f1, f2, f3;
  logic [1:0]  fa, fb, st;
  logic [15:0] sc, fc;
  logic        pcw2, ifw2, bub2, g1, g2, g3;
  logic [1:0]  fa2, fb2, st2;
  logic [1:0]  sc2, fc2;

  int n_vec = 0;
  int n_err = 0;

  int m_state = 0;
  int m_sc = 0, m_fc = 0, m_sc2 = 0, m_fc2 = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(16)) u1 (
    .clk(clk), .reset(reset),
    .IF_ID_rs1_i(if_rs1), .IF_ID_rs2_i(if_rs2),
    .ID_EX_rs1_i(ex_rs1), .ID_EX_rs2_i(ex_rs2),
    .ID_EX_rd_i(ex_rd), .ID_EX_mem_read_i(ex_mr),
    .EX_MEM_rd_i(mem_rd), .EX_MEM_reg_write_i(mem_rw),
    .EX_MEM_branch_i(mem_br), .EX_MEM_zero_i(mem_z),
    .EX_MEM_jalr_i(mem_jalr),
    .MEM_WB_rd_i(wb_rd), .MEM_WB_reg_write_i(wb_rw),
    .pc_write_o(pcw), .if_id_write_o(ifw),
    .id_ex_bubble_o(bub), .if_id_flush_o(f1),
    .id_ex_flush_o(f2), .ex_mem_flush_o(f3),
    .forward_a_o(fa), .forward_b_o(fb),
    .state_o(st), .stall_count_o(sc), .flush_count_o(fc)
  );

  pipeline_hazard_controller #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset),
    .IF_ID_rs1_i(if_rs1), .IF_ID_rs2_i(if_rs2),
    .ID_EX_rs1_i(ex_rs1), .ID_EX_rs2_i(ex_rs2),
    .ID_EX_rd_i(ex_rd), .ID_EX_mem_read_i(ex_mr),
    .EX_MEM_rd_i(mem_rd), .EX_MEM_reg_write_i(mem_rw),
    .EX_MEM_branch_i(mem_br), .EX_MEM_zero_i(mem_z),
    .EX_MEM_jalr_i(mem_jalr),
    .MEM_WB_rd_i(wb_rd), .MEM_WB_reg_write_i(wb_rw),
    .pc_write_o(pcw2), .if_id_write_o(ifw2),
    .id_ex_bubble_o(bub2), .if_id_flush_o(g1),
    .id_ex_flush_o(g2), .ex_mem_flush_o(g3),
    .forward_a_o(fa2), .forward_b_o(fb2),
    .state_o(st2), .stall_count_o(sc2), .flush_count_o(fc2)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_redir();
    return mem_jalr || (mem_br && mem_z);
  endfunction

  function automatic bit m_lu();
    return ex_mr && ex_rd != 0 && (ex_rd == if_rs1 || ex_rd == if_rs2);
  endfunction

  function automatic int m_fwd(input logic [4:0] rs);
    if (mem_rw && mem_rd != 0 && mem_rd == rs) return 2;
    if (wb_rw && wb_rd != 0 && wb_rd == rs) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0;
      m_sc <= 0; m_fc <= 0; m_sc2 <= 0; m_fc2 <= 0;
    end else begin
      m_state <= m_redir() ? 2 : (m_lu() ? 1 : 0);
      if (m_lu() && !m_redir()) begin
        if (m_sc < 65535) m_sc <= m_sc + 1;
        if (m_sc2 < 3) m_sc2 <= m_sc2 + 1;
      end
      if (m_redir()) begin
        if (m_fc < 65535) m_fc <= m_fc + 1;
        if (m_fc2 < 3) m_fc2 <= m_fc2 + 1;
      end
    end
  end

  always @(negedge clk) begin
    automatic bit r  = !reset && m_redir();
    automatic bit s  = !reset && !m_redir() && m_lu();
    automatic int ea = reset ? 0 : m_fwd(ex_rs1);
    automatic int eb = reset ? 0 : m_fwd(ex_rs2);
    chk("pc_write", pcw, !s);
    chk("if_id_write", ifw, !s);
    chk("bubble", bub, s);
    chk("if_id_flush", f1, r);
    chk("id_ex_flush", f2, r);
    chk("ex_mem_flush", f3, r);
    chk("fwd_a", fa, ea);
    chk("fwd_b", fb, eb);
    chk("state", st, m_state);
    chk("stall_cnt", sc, m_sc);
    chk("flush_cnt", fc, m_fc);
    chk("w2_bubble", bub2, s);
    chk("w2_flush", g3, r);
    chk("w2_state", st2, m_state);
    chk("w2_stall_cnt", sc2, m_sc2);
    chk("w2_flush_cnt", fc2, m_fc2);
  end

  task automatic clr();
    if_rs1 = 0; if_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_mr = 0; mem_rd = 0; mem_rw = 0; mem_br = 0; mem_z = 0;
    mem_jalr = 0; wb_rd = 0; wb_rw = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mr = 1; ex_rd = rd; if_rs1 = 5; if_rs2 = 9;
  endtask

  initial begin
    reset = 1;
    clr();
    set_lu(5);
    mem_br = 1; mem_z = 1;
    mem_rw = 1; mem_rd = 3; ex_rs1 = 3;
    #1;
    chk("rst_pc_write", pcw, 1);
    chk("rst_flush", f1, 0);
    chk("rst_fwd_a", fa, 0);
    step(); step();
    chk("rst_state", st, 0);
    chk("rst_flush_cnt", fc, 0);
    reset = 0;
    clr();
    step();

    set_lu(5);
    #1;
    chk("lu_pc_write", pcw, 0);
    chk("lu_if_id_write", ifw, 0);
    chk("lu_bubble", bub, 1);
    step();
    clr();
    #1;
    chk("lu_state", st, 1);
    chk("lu_stall_cnt", sc, 1);
    step();
    chk("lu_state2", st, 0);
    chk("lu_stall_cnt2", sc, 1);

    set_lu(0);
    #1;
    chk("x0_bubble", bub, 0);
    step();
    clr();
    #1;
    chk("x0_stall_cnt", sc, 1);

    set_lu(5);
    step();
    clr();
    #1;
    chk("pre_rst_state", st, 1);
    chk("pre_rst_stall", sc, 2);
    reset = 1;
    step();
    chk("mid_rst_state", st, 0);
    chk("mid_rst_stall", sc, 0);
    chk("mid_rst_flush", fc, 0);
    reset = 0;

    set_lu(5);
    mem_br = 1; mem_z = 1;
    #1;
    chk("pri_flush1", f1, 1);
    chk("pri_flush3", f3, 1);
    chk("pri_bubble", bub, 0);
    chk("pri_pc_write", pcw, 1);
    step();
    clr();
    #1;
    chk("pri_state", st, 2);
    chk("pri_flush_cnt", fc, 1);
    chk("pri_stall_cnt", sc, 0);
    step();
    chk("pri_state2", st, 0);

    mem_rw = 1; mem_rd = 3; wb_rw = 1; wb_rd = 3;
    ex_rs1 = 3; ex_rs2 = 3;
    #1;
    chk("fwd_ex_a", fa, 2);
    chk("fwd_ex_b", fb, 2);
    mem_rw = 0;
    #1;
    chk("fwd_wb_a", fa, 1);
    chk("fwd_wb_b", fb, 1);
    wb_rd = 0;
    #1;
    chk("fwd_x0_a", fa, 0);
    step();
    clr();

    reset = 1;
    step();
    reset = 0;
    mem_jalr = 1;
    for (int i = 0; i < 5; i++) begin
      automatic int want[5] = '{1, 2, 3, 3, 3};
      step();
      chk("sat_flush_cnt", fc2, want[i]);
      chk("wide_flush_cnt", fc, i + 1);
    end
    clr();
    step();

    for (int i = 0; i < 300; i++) begin
      reset    = ($urandom_range(0, 29) == 0);
      if_rs1   = 5'($urandom_range(0, 3));
      if_rs2   = 5'($urandom_range(0, 3));
      ex_rs1   = 5'($urandom_range(0, 3));
      ex_rs2   = 5'($urandom_range(0, 3));
      ex_rd    = 5'($urandom_range(0, 3));
      ex_mr    = 1'($urandom_range(0, 1));
      mem_rd   = 5'($urandom_range(0, 3));
      mem_rw   = 1'($urandom_range(0, 1));
      mem_br   = ($urandom_range(0, 3) == 0);
      mem_z    = 1'($urandom_range(0, 1));
      mem_jalr = ($urandom_range(0, 7) == 0);
      wb_rd    = 5'($urandom_range(0, 3));
      wb_rw    = 1'($urandom_range(0, 1));
      step();
    end
    reset = 0;
    clr();
    step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
